// File: rtl/alu_seq_pipe_if.sv
// Operand/result handshake bundle for alu_seq_pipe.
// master = operand sequencer / writeback side, slave = the ALU.
interface alu_seq_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 enable;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [4:0]           command;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   y;
  logic                 zero;
  logic                 err;

  modport master (
    output enable, in_valid, a, b, command, out_ready,
    input  in_ready, out_valid, y, zero, err
  );

  modport slave (
    input  enable, in_valid, a, b, command, out_ready,
    output in_ready, out_valid, y, zero, err
  );
endinterface

// File: rtl/alu_seq_pipe.sv
// Registered command ALU: single-cycle logic/arith ops, iterative MUL/DIV/MOD
// (shift-add / restoring divide, one step per clock) behind a valid/ready pair.
module alu_seq_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_seq_pipe_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = SW + 1;

  typedef enum logic [4:0] {
    OP_ADD = 5'h00, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_XOR,
    OP_NAND, OP_NOR, OP_XNOR, OP_NOT, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
    OP_INC, OP_DEC, OP_EQ, OP_GT, OP_LT, OP_PASSA, OP_PASSB, OP_CLR
  } op_t;

  typedef enum logic { S_IDLE, S_BUSY } state_t;
  typedef enum logic [1:0] { K_MUL, K_DIV, K_MOD } kind_t;

  state_t             r_state, w_next_state;
  kind_t              r_kind;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_m;
  logic [2*WIDTH-1:0] r_y;
  logic               r_zero, r_err, r_out_valid;

  logic               w_in_ready, w_accept, w_multi, w_load, w_load_err, w_fast_err, w_ge;
  logic [2*WIDTH-1:0] w_load_y, w_fast_y;
  logic [SW-1:0]      w_sh;
  logic [CW-1:0]      w_rsh;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [WIDTH-1:0]   w_diff, w_nhi, w_nlo;

  assign w_in_ready = rst_n & bus.enable & (r_state == S_IDLE) & (~r_out_valid | bus.out_ready);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_multi    = (bus.command == OP_MUL) || (bus.command == OP_DIV) || (bus.command == OP_MOD);
  assign w_sh       = bus.b[SW-1:0];
  assign w_rsh      = CW'(WIDTH) - {1'b0, w_sh};

  // {r_hi,r_lo} is the product/shift pair for MUL and the remainder/quotient pair for DIV/MOD.
  // With b==0 every trial subtract succeeds, leaving quotient all ones and remainder a.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_m});
    w_diff  = w_shift[WIDTH-1:0] - r_m;
    if (r_kind == K_MUL) begin
      w_nhi = w_sum[WIDTH:1];
      w_nlo = {w_sum[0], r_lo[WIDTH-1:1]};
    end else begin
      w_nhi = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  always_comb begin
    w_fast_y   = '0;
    w_fast_err = 1'b0;
    case (bus.command)
      OP_ADD:   w_fast_y = {{(WIDTH-1){1'b0}}, {1'b0, bus.a} + {1'b0, bus.b}};
      OP_SUB:   w_fast_y = {{WIDTH{1'b0}}, bus.a} - {{WIDTH{1'b0}}, bus.b};
      OP_MUL, OP_DIV, OP_MOD: w_fast_y = '0;
      OP_AND:   w_fast_y = {{WIDTH{1'b0}}, bus.a & bus.b};
      OP_OR:    w_fast_y = {{WIDTH{1'b0}}, bus.a | bus.b};
      OP_XOR:   w_fast_y = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      OP_NAND:  w_fast_y = {{WIDTH{1'b0}}, ~(bus.a & bus.b)};
      OP_NOR:   w_fast_y = {{WIDTH{1'b0}}, ~(bus.a | bus.b)};
      OP_XNOR:  w_fast_y = {{WIDTH{1'b0}}, ~(bus.a ^ bus.b)};
      OP_NOT:   w_fast_y = {{WIDTH{1'b0}}, ~bus.a};
      OP_SHL:   w_fast_y = {{WIDTH{1'b0}}, bus.a << w_sh};
      OP_SHR:   w_fast_y = {{WIDTH{1'b0}}, bus.a >> w_sh};
      OP_ROL:   w_fast_y = {{WIDTH{1'b0}}, (bus.a << w_sh) | (bus.a >> w_rsh)};
      OP_ROR:   w_fast_y = {{WIDTH{1'b0}}, (bus.a >> w_sh) | (bus.a << w_rsh)};
      OP_INC:   w_fast_y = {{WIDTH{1'b0}}, bus.a + WIDTH'(1)};
      OP_DEC:   w_fast_y = {{WIDTH{1'b0}}, bus.a - WIDTH'(1)};
      OP_EQ:    w_fast_y = {{(2*WIDTH-1){1'b0}}, bus.a == bus.b};
      OP_GT:    w_fast_y = {{(2*WIDTH-1){1'b0}}, bus.a > bus.b};
      OP_LT:    w_fast_y = {{(2*WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_PASSA: w_fast_y = {{WIDTH{1'b0}}, bus.a};
      OP_PASSB: w_fast_y = {{WIDTH{1'b0}}, bus.b};
      OP_CLR:   w_fast_y = '0;
      default:  w_fast_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_load_y     = w_fast_y;
    w_load_err   = w_fast_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_multi) w_next_state = S_BUSY;
          else         w_load       = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt == CW'(1)) begin
          w_next_state = S_IDLE;
          w_load       = 1'b1;
          w_load_y     = (r_kind == K_MOD) ? {{WIDTH{1'b0}}, w_nhi} : {w_nhi, w_nlo};
          w_load_err   = (r_kind != K_MUL) && (r_m == '0);
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind <= K_MUL;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_m    <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_multi) begin
        r_kind <= (bus.command == OP_MUL) ? K_MUL : (bus.command == OP_DIV) ? K_DIV : K_MOD;
        r_cnt  <= CW'(WIDTH);
        r_hi   <= '0;
        r_lo   <= (bus.command == OP_MUL) ? bus.b : bus.a;
        r_m    <= (bus.command == OP_MUL) ? bus.a : bus.b;
      end
    end else begin
      r_cnt <= r_cnt - CW'(1);
      r_hi  <= w_nhi;
      r_lo  <= w_nlo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_y         <= w_load_y;
      r_zero      <= (w_load_y == '0);
      r_err       <= w_load_err;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.zero      = r_zero;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_seq_pipe.sv
// Bench for alu_seq_pipe (WIDTH=8): directed handshake scenarios plus random
// operations checked against an integer-arithmetic reference model.
module tb_alu_seq_pipe;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_seq_pipe_if #(.WIDTH(W)) bus ();
  alu_seq_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: results from plain unsigned integer arithmetic; lat = edges after accept.
  function automatic void model(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2*W-1:0] y, output logic e, output int lat);
    longint unsigned ai = a, bi = b, m = (64'd1 << W) - 1, m2 = (64'd1 << (2*W)) - 1, r;
    int unsigned s = b % W;
    e = 1'b0; lat = 0; r = 0;
    case (c)
      5'd0:  r = ai + bi;
      5'd1:  r = (ai - bi) & m2;
      5'd2:  begin r = ai * bi; lat = W; end
      5'd3:  begin lat = W; if (bi == 0) begin r = (ai << W) | m; e = 1'b1; end
                   else r = ((ai % bi) << W) | (ai / bi); end
      5'd4:  begin lat = W; if (bi == 0) begin r = ai; e = 1'b1; end else r = ai % bi; end
      5'd5:  r = ai & bi;
      5'd6:  r = ai | bi;
      5'd7:  r = ai ^ bi;
      5'd8:  r = ~(ai & bi) & m;
      5'd9:  r = ~(ai | bi) & m;
      5'd10: r = ~(ai ^ bi) & m;
      5'd11: r = ~ai & m;
      5'd12: r = (ai << s) & m;
      5'd13: r = ai >> s;
      5'd14: r = ((ai << s) | (ai >> (W - s))) & m;
      5'd15: r = ((ai >> s) | (ai << (W - s))) & m;
      5'd16: r = (ai + 1) & m;
      5'd17: r = (ai - 1) & m;
      5'd18: r = (ai == bi) ? 1 : 0;
      5'd19: r = (ai > bi) ? 1 : 0;
      5'd20: r = (ai < bi) ? 1 : 0;
      5'd21: r = ai;
      5'd22: r = bi;
      5'd23: r = 0;
      default: begin r = 0; e = 1'b1; end
    endcase
    y = r[2*W-1:0];
  endfunction

  // One complete transaction: accept, wait for result, hold it `hold` cycles, consume.
  task automatic do_op(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [2*W-1:0] ey;
    logic ee;
    int el, n;
    model(c, a, b, ey, ee, el);
    @(negedge clk);
    bus.command = c; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      chk("accept_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.command = 5'($urandom);
    @(negedge clk);
    n = 0;
    while (!bus.out_valid && n < 3*W) begin
      chk("busy_in_ready", bus.in_ready, 0);
      @(negedge clk); n++;
    end
    chk($sformatf("lat_op%0d", c), n, el);
    chk("out_valid", bus.out_valid, 1);
    chk($sformatf("y_op%0d_a%0d_b%0d", c, a, b), bus.y, ey);
    chk($sformatf("err_op%0d", c), bus.err, ee);
    chk("zero", bus.zero, (ey == 0));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_y", bus.y, ey);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("consumed", bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] c;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    bus.enable = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.command = '0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_err", bus.err, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ADD then SUB with out_ready held high.
    @(negedge clk);
    bus.command = 5'd0; bus.a = 8'd15; bus.b = 8'd10; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    chk("b2b_in_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("add_valid", bus.out_valid, 1);
    chk("add_y", bus.y, 25);
    chk("add_zero", bus.zero, 0);
    chk("add_err", bus.err, 0);
    bus.command = 5'd1; bus.a = 8'd25; bus.b = 8'd5;
    chk("b2b_in_ready2", bus.in_ready, 1);
    @(negedge clk);
    chk("sub_valid", bus.out_valid, 1);
    chk("sub_y", bus.y, 20);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drained", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // Spec corner cases.
    do_op(5'd2, 8'd200, 8'd200, 0);
    do_op(5'd3, 8'd40, 8'd0, 1);
    do_op(5'd3, 8'd40, 8'd8, 0);
    do_op(5'd4, 8'd40, 8'd7, 0);
    do_op(5'd4, 8'd40, 8'd0, 0);
    do_op(5'd2, 8'd255, 8'd255, 0);
    do_op(5'd3, 8'd255, 8'd1, 0);
    do_op(5'd24, 8'd3, 8'd4, 0);
    do_op(5'd1, 8'd5, 8'd10, 0);
    do_op(5'd16, 8'd255, 8'd0, 0);
    do_op(5'd17, 8'd0, 8'd0, 0);

    // Backpressure: result 25 held, then consume and load on one edge.
    @(negedge clk);
    bus.command = 5'd0; bus.a = 8'd15; bus.b = 8'd10; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.command = 5'd1; bus.a = 8'd9; bus.b = 8'd4;
    repeat (3) begin
      chk("bp_y", bus.y, 25);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("bp_swap_valid", bus.out_valid, 1);
    chk("bp_swap_y", bus.y, 5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", bus.out_valid, 0);

    // enable low refuses new work.
    bus.enable = 1'b0; bus.in_valid = 1'b1; bus.command = 5'd0;
    repeat (3) begin
      #1;
      chk("dis_in_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("dis_no_result", bus.out_valid, 0);
    end
    bus.in_valid = 1'b0; bus.enable = 1'b1; bus.out_ready = 1'b0;

    // Reset during a multiply aborts it.
    @(negedge clk);
    bus.command = 5'd2; bus.a = 8'd200; bus.b = 8'd200; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_y", bus.y, 0);
    chk("abort_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_ready_after", bus.in_ready, 1);
    repeat (W + 2) begin
      @(negedge clk);
      chk("abort_no_result", bus.out_valid, 0);
    end
    do_op(5'd0, 8'd15, 8'd10, 0);

    // Random operations, including illegal opcodes, b==0 and backpressure.
    for (int i = 0; i < 120; i++) begin
      c  = 5'($urandom_range(0, 31));
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_op(c, ra, rb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
